// File: rtl/atm_session_core.sv
// ATM session controller with an on-chip account table (ID, password, balance, lock state).
// It authenticates cards with a retry lockout and runs withdraw, show-balance and transfer.
module atm_session_core #(
  parameter int unsigned N_ACCOUNTS = 10,
  parameter int unsigned ID_W       = 8,
  parameter int unsigned PASS_W     = 8,
  parameter int unsigned BAL_W      = 8,
  parameter int unsigned MAX_TRIES  = 3,
  localparam int unsigned IDX_W     = $clog2(N_ACCOUNTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enter_i,
  input  logic [ID_W-1:0]   id_i,
  input  logic [PASS_W-1:0] password_i,
  input  logic [ID_W-1:0]   dest_id_i,
  input  logic [2:0]        control_i,
  input  logic [BAL_W-1:0]  request_i,
  input  logic              back_i,
  input  logic              eject_i,
  input  logic              cfg_we_i,
  input  logic [IDX_W-1:0]  cfg_idx_i,
  input  logic [ID_W-1:0]   cfg_id_i,
  input  logic [PASS_W-1:0] cfg_pass_i,
  input  logic [BAL_W-1:0]  cfg_bal_i,
  output logic              err_pass_o,
  output logic              err_id_o,
  output logic              err_lock_o,
  output logic              err_balance_o,
  output logic              err_transf_o,
  output logic              done_o,
  output logic [BAL_W-1:0]  balance_value_o,
  output logic [2:0]        state_out_o
);

  typedef enum logic [2:0] {
    StMenu         = 3'b000,
    StCheckPass    = 3'b001,
    StShowBalance  = 3'b010,
    StWithdraw     = 3'b011,
    StWithdrawShow = 3'b100,
    StTransfer     = 3'b101
  } state_e;

  localparam logic [IDX_W:0] NumAcc = (IDX_W+1)'(N_ACCOUNTS);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   session_q, session_d;
  logic               valid_q [N_ACCOUNTS];
  logic               valid_d [N_ACCOUNTS];
  logic               lock_q  [N_ACCOUNTS];
  logic               lock_d  [N_ACCOUNTS];
  logic [2:0]         fail_q  [N_ACCOUNTS];
  logic [2:0]         fail_d  [N_ACCOUNTS];
  logic [ID_W-1:0]    id_q    [N_ACCOUNTS];
  logic [ID_W-1:0]    id_d    [N_ACCOUNTS];
  logic [PASS_W-1:0]  pass_q  [N_ACCOUNTS];
  logic [PASS_W-1:0]  pass_d  [N_ACCOUNTS];
  logic [BAL_W-1:0]   bal_q   [N_ACCOUNTS];
  logic [BAL_W-1:0]   bal_d   [N_ACCOUNTS];
  logic               err_pass_q, err_pass_d, err_id_q, err_id_d, err_lock_q, err_lock_d;
  logic               err_bal_q, err_bal_d, err_transf_q, err_transf_d;
  logic               done_q, done_d;
  logic [BAL_W-1:0]   show_q, show_d;

  logic               id_hit, dest_hit;
  logic [IDX_W-1:0]   id_idx, dest_idx;
  logic [BAL_W-1:0]   src_bal, dst_bal;
  logic [BAL_W:0]     dst_sum;

  // Descending scan so the lowest matching slot is the one left standing.
  always_comb begin
    id_hit   = 1'b0;
    id_idx   = '0;
    dest_hit = 1'b0;
    dest_idx = '0;
    for (int i = int'(N_ACCOUNTS) - 1; i >= 0; i--) begin
      if (valid_q[i] && id_q[i] == id_i) begin
        id_hit = 1'b1;
        id_idx = IDX_W'(i);
      end
      if (valid_q[i] && id_q[i] == dest_id_i) begin
        dest_hit = 1'b1;
        dest_idx = IDX_W'(i);
      end
    end
  end

  assign src_bal = bal_q[session_q];
  assign dst_bal = bal_q[dest_idx];
  assign dst_sum = {1'b0, dst_bal} + {1'b0, request_i};

  always_comb begin
    state_d      = state_q;
    session_d    = session_q;
    valid_d      = valid_q;
    lock_d       = lock_q;
    fail_d       = fail_q;
    id_d         = id_q;
    pass_d       = pass_q;
    bal_d        = bal_q;
    err_pass_d   = err_pass_q;
    err_id_d     = err_id_q;
    err_lock_d   = err_lock_q;
    err_bal_d    = err_bal_q;
    err_transf_d = err_transf_q;
    done_d       = 1'b0;

    if (eject_i) begin
      state_d      = StCheckPass;
      session_d    = '0;
      {err_pass_d, err_id_d, err_lock_d, err_bal_d, err_transf_d} = '0;
    end else if (back_i && state_q != StCheckPass) begin
      state_d      = StMenu;
      {err_pass_d, err_id_d, err_lock_d, err_bal_d, err_transf_d} = '0;
    end else if (cfg_we_i && state_q == StCheckPass) begin
      if ({1'b0, cfg_idx_i} < NumAcc) begin
        valid_d[cfg_idx_i] = 1'b1;
        lock_d[cfg_idx_i]  = 1'b0;
        fail_d[cfg_idx_i]  = '0;
        id_d[cfg_idx_i]    = cfg_id_i;
        pass_d[cfg_idx_i]  = cfg_pass_i;
        bal_d[cfg_idx_i]   = cfg_bal_i;
      end
    end else if (enter_i) begin
      unique case (state_q)
        StCheckPass: begin
          {err_pass_d, err_id_d, err_lock_d, err_bal_d, err_transf_d} = '0;
          if (!id_hit) begin
            err_id_d = 1'b1;
          end else if (lock_q[id_idx]) begin
            err_lock_d = 1'b1;
          end else if (pass_q[id_idx] != password_i) begin
            err_pass_d     = 1'b1;
            fail_d[id_idx] = fail_q[id_idx] + 3'd1;
            if (fail_q[id_idx] + 3'd1 >= 3'(MAX_TRIES)) lock_d[id_idx] = 1'b1;
          end else begin
            fail_d[id_idx] = '0;
            session_d      = id_idx;
            done_d         = 1'b1;
            state_d        = StMenu;
          end
        end
        StMenu: begin
          if (control_i inside {3'b010, 3'b011, 3'b100, 3'b101}) begin
            {err_pass_d, err_id_d, err_lock_d, err_bal_d, err_transf_d} = '0;
            state_d = state_e'(control_i);
          end
        end
        StWithdraw, StWithdrawShow: begin
          {err_pass_d, err_id_d, err_lock_d, err_bal_d, err_transf_d} = '0;
          if (request_i <= src_bal) begin
            bal_d[session_q] = src_bal - request_i;
            done_d           = 1'b1;
          end else begin
            err_bal_d = 1'b1;
          end
          state_d = (state_q == StWithdraw) ? StMenu : StShowBalance;
        end
        StTransfer: begin
          {err_pass_d, err_id_d, err_lock_d, err_bal_d, err_transf_d} = '0;
          if (!dest_hit || dest_idx == session_q) begin
            err_id_d     = 1'b1;
            err_transf_d = 1'b1;
          end else if (request_i > src_bal) begin
            err_bal_d    = 1'b1;
            err_transf_d = 1'b1;
          end else if (dst_sum[BAL_W]) begin
            err_transf_d = 1'b1;
          end else begin
            bal_d[session_q] = src_bal - request_i;
            bal_d[dest_idx]  = dst_sum[BAL_W-1:0];
            done_d           = 1'b1;
          end
          state_d = StShowBalance;
        end
        default: ;
      endcase
    end

    show_d = (state_d == StShowBalance) ? bal_d[session_d] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StCheckPass;
      session_q    <= '0;
      err_pass_q   <= 1'b0;
      err_id_q     <= 1'b0;
      err_lock_q   <= 1'b0;
      err_bal_q    <= 1'b0;
      err_transf_q <= 1'b0;
      done_q       <= 1'b0;
      show_q       <= '0;
      for (int i = 0; i < int'(N_ACCOUNTS); i++) begin
        valid_q[i] <= 1'b0;
        lock_q[i]  <= 1'b0;
        fail_q[i]  <= '0;
        id_q[i]    <= '0;
        pass_q[i]  <= '0;
        bal_q[i]   <= '0;
      end
    end else begin
      state_q      <= state_d;
      session_q    <= session_d;
      err_pass_q   <= err_pass_d;
      err_id_q     <= err_id_d;
      err_lock_q   <= err_lock_d;
      err_bal_q    <= err_bal_d;
      err_transf_q <= err_transf_d;
      done_q       <= done_d;
      show_q       <= show_d;
      valid_q      <= valid_d;
      lock_q       <= lock_d;
      fail_q       <= fail_d;
      id_q         <= id_d;
      pass_q       <= pass_d;
      bal_q        <= bal_d;
    end
  end

  assign err_pass_o      = err_pass_q;
  assign err_id_o        = err_id_q;
  assign err_lock_o      = err_lock_q;
  assign err_balance_o   = err_bal_q;
  assign err_transf_o    = err_transf_q;
  assign done_o          = done_q;
  assign balance_value_o = show_q;
  assign state_out_o     = state_q;

endmodule

// File: tb/tb_atm_session_core.sv
// Directed self-checking bench for atm_session_core: login, lockout, withdraw, transfer, abort.
module tb_atm_session_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enter_i = 1'b0, back_i = 1'b0, eject_i = 1'b0, cfg_we_i = 1'b0;
  logic [7:0] id_i = '0, password_i = '0, dest_id_i = '0, request_i = '0;
  logic [2:0] control_i = '0;
  logic [3:0] cfg_idx_i = '0;
  logic [7:0] cfg_id_i = '0, cfg_pass_i = '0, cfg_bal_i = '0;
  logic       err_pass_o, err_id_o, err_lock_o, err_balance_o, err_transf_o, done_o;
  logic [7:0] balance_value_o;
  logic [2:0] state_out_o;

  int n_checks = 0;
  int n_fail   = 0;

  atm_session_core dut (
    .clk(clk), .rst_n(rst_n), .enter_i(enter_i), .id_i(id_i), .password_i(password_i),
    .dest_id_i(dest_id_i), .control_i(control_i), .request_i(request_i), .back_i(back_i),
    .eject_i(eject_i), .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_id_i(cfg_id_i),
    .cfg_pass_i(cfg_pass_i), .cfg_bal_i(cfg_bal_i), .err_pass_o(err_pass_o),
    .err_id_o(err_id_o), .err_lock_o(err_lock_o), .err_balance_o(err_balance_o),
    .err_transf_o(err_transf_o), .done_o(done_o), .balance_value_o(balance_value_o),
    .state_out_o(state_out_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [3:0] idx, input logic [7:0] id, input logic [7:0] pw,
                     input logic [7:0] bal);
    cfg_we_i = 1'b1; cfg_idx_i = idx; cfg_id_i = id; cfg_pass_i = pw; cfg_bal_i = bal;
    tick();
    cfg_we_i = 1'b0;
  endtask

  task automatic login(input logic [7:0] id, input logic [7:0] pw);
    id_i = id; password_i = pw; enter_i = 1'b1;
    tick();
    enter_i = 1'b0;
  endtask

  task automatic sel(input logic [2:0] ctrl);
    control_i = ctrl; enter_i = 1'b1;
    tick();
    enter_i = 1'b0;
  endtask

  task automatic op(input logic [7:0] req, input logic [7:0] dest);
    request_i = req; dest_id_i = dest; enter_i = 1'b1;
    tick();
    enter_i = 1'b0;
  endtask

  task automatic pulse_back();
    back_i = 1'b1;
    tick();
    back_i = 1'b0;
  endtask

  task automatic pulse_eject();
    eject_i = 1'b1;
    tick();
    eject_i = 1'b0;
  endtask

  initial begin
    #12;
    check_eq("reset_state", {29'd0, state_out_o}, 32'd1);
    check_eq("reset_outs", {err_pass_o, err_id_o, err_lock_o, err_balance_o, err_transf_o,
                            done_o, balance_value_o}, 32'd0);
    rst_n = 1'b1;
    tick();

    cfg(4'd0, 8'h11, 8'h22, 8'd100);
    login(8'h11, 8'h22);
    check_eq("login_done", {31'd0, done_o}, 32'd1);
    check_eq("login_state", {29'd0, state_out_o}, 32'd0);
    tick();
    check_eq("done_one_cycle", {31'd0, done_o}, 32'd0);
    sel(3'b111);
    check_eq("bad_code_stays", {29'd0, state_out_o}, 32'd0);

    pulse_eject();
    check_eq("eject_state", {29'd0, state_out_o}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      login(8'h11, 8'h00);
      check_eq("wrong_pass", {30'd0, err_pass_o, err_lock_o}, 32'b10);
    end
    login(8'h11, 8'h22);
    check_eq("locked_flags", {29'd0, err_pass_o, err_lock_o, done_o}, 32'b010);
    check_eq("locked_state", {29'd0, state_out_o}, 32'd1);
    cfg(4'd0, 8'h11, 8'h22, 8'd100);
    login(8'h11, 8'h22);
    check_eq("relogin_done", {31'd0, done_o}, 32'd1);

    sel(3'b100);
    check_eq("sel_wshow", {29'd0, state_out_o}, 32'd4);
    op(8'd40, 8'h00);
    check_eq("wshow_state", {29'd0, state_out_o}, 32'd2);
    check_eq("wshow_bal", {24'd0, balance_value_o}, 32'd60);
    check_eq("wshow_done", {31'd0, done_o}, 32'd1);
    pulse_back();
    check_eq("back_menu", {21'd0, state_out_o, balance_value_o}, {21'd0, 3'd0, 8'd0});
    sel(3'b100);
    op(8'd70, 8'h00);
    check_eq("wshow_err", {30'd0, err_balance_o, done_o}, 32'b10);
    check_eq("wshow_bal_keep", {24'd0, balance_value_o}, 32'd60);

    pulse_back();
    cfg(4'd2, 8'h55, 8'h66, 8'd9);
    pulse_eject();
    login(8'h55, 8'h66);
    check_eq("cfg_outside_ignored", {31'd0, err_id_o}, 32'd1);

    cfg(4'd1, 8'h33, 8'h44, 8'd250);
    login(8'h11, 8'h22);
    sel(3'b101);
    op(8'd10, 8'h33);
    check_eq("xfer_ovf_flags", {27'd0, err_id_o, err_balance_o, err_transf_o, done_o},
             32'b0010);
    check_eq("xfer_ovf_bal", {21'd0, state_out_o, balance_value_o}, {21'd0, 3'd2, 8'd60});
    pulse_back();
    sel(3'b101);
    op(8'd5, 8'h33);
    check_eq("xfer_ok", {29'd0, err_transf_o, done_o, 1'b0}, 32'b010);
    check_eq("xfer_src_bal", {24'd0, balance_value_o}, 32'd55);
    pulse_back();
    sel(3'b101);
    op(8'd1, 8'h11);
    check_eq("xfer_self", {30'd0, err_id_o, err_transf_o}, 32'b11);
    pulse_back();
    sel(3'b101);
    op(8'd1, 8'h99);
    check_eq("xfer_unknown", {30'd0, err_id_o, err_transf_o}, 32'b11);
    check_eq("xfer_unknown_bal", {24'd0, balance_value_o}, 32'd55);

    pulse_eject();
    login(8'h33, 8'h44);
    sel(3'b010);
    check_eq("dest_bal", {24'd0, balance_value_o}, 32'd255);
    pulse_back();
    sel(3'b011);
    check_eq("sel_withdraw", {29'd0, state_out_o}, 32'd3);
    request_i = 8'd100; eject_i = 1'b1; enter_i = 1'b1;
    tick();
    eject_i = 1'b0; enter_i = 1'b0;
    check_eq("eject_beats_enter", {29'd0, state_out_o}, 32'd1);
    login(8'h33, 8'h44);
    sel(3'b011);
    op(8'd0, 8'h00);
    check_eq("withdraw_zero", {28'd0, done_o, err_balance_o, state_out_o[1:0]}, 32'b1000);
    sel(3'b010);
    check_eq("bal_after_eject", {24'd0, balance_value_o}, 32'd255);

    #3 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    check_eq("midreset_state", {29'd0, state_out_o}, 32'd1);
    check_eq("midreset_outs", {err_pass_o, err_id_o, err_lock_o, err_balance_o, err_transf_o,
                               done_o, balance_value_o}, 32'd0);
    tick();
    login(8'h11, 8'h22);
    check_eq("midreset_login", {30'd0, err_id_o, done_o}, 32'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
